io_panel_port: RTL and testbench

- Memory-mapped I/O responder on the CPU's mem_io cycles. The CPU is the initiator; this block is the target.
- Replaces the simulation-only debug peripheral with synthesizable logic:
  - debounced clockwise/anticlockwise button inputs with sticky press events;
  - an 8x8 LED frame buffer, row-scanned onto led_x/led_y.
- Sits beside ram at machine top level; the top level drives the tristate bus from dout/dout_en.

---
 rtl/io_panel_pkg.sv | 28 ++
 rtl/io_panel_port_btn_debounce.sv | 46 ++++
 rtl/io_panel_port.sv | 190 +++++++++++++++++++
 tb/tb_io_panel_port.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_panel_pkg.sv
// Shared definitions for the I/O panel port: register addresses and bit positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package io_panel_pkg;

  // I/O port addresses decoded by io_panel_port
  localparam logic [7:0] IO_ADDR_DBG     = 8'h00;
  localparam logic [7:0] IO_ADDR_BTN     = 8'h01;
  localparam logic [7:0] IO_ADDR_ROWPTR  = 8'h02;
  localparam logic [7:0] IO_ADDR_ROWDATA = 8'h03;
  localparam logic [7:0] IO_ADDR_CTRL    = 8'h04;

  // CTRL register bits
  localparam int CTRL_SCAN_EN  = 0;
  localparam int CTRL_IRQ_MASK = 1;

  // BTN register bits
  localparam int BTN_ACW_EVT = 0;
  localparam int BTN_CW_EVT  = 1;
  localparam int BTN_ACW_LVL = 2;
  localparam int BTN_CW_LVL  = 3;

  // Addresses 0x00..0x04 are the only ones this block answers.
  function automatic logic addr_mapped(input logic [7:0] a);
    return (a <= IO_ADDR_CTRL);
  endfunction

endpackage

// File: rtl/io_panel_port_btn_debounce.sv
// Button conditioner: 2-FF synchronizer plus stability counter, one instance per button.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES cycles of a steady level before stable follows.
// Backpressure: none; free-running on every clk.
//
// Ports:
//   clk, reset (sync, active-low)
//   btn     asynchronous raw button level
//   stable  debounced level
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic stable
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync1;
  logic        sync2;
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      // Count only while the synchronized level disagrees with the accepted
      // one; any return to agreement restarts the qualification window.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/io_panel_port.sv
// Memory-mapped I/O target: debug scratch register, debounced buttons, scanned 8x8 LED frame.
// Latency: writes commit at strobe start; reads are combinational; LED outputs are 1 cycle behind.
// Backpressure: none; every strobe completes, exactly one side effect per strobe.
//
// Optional feature macro: IO_PANEL_IRQ_EN (adds registered irq output and CTRL irq_mask bit).
//
// Ports:
//   clk, reset (sync, active-low)
//   io_sel, io_strb, io_we, io_oe, addr[7:0], din[7:0]   CPU access
//   dout[7:0], dout_en                                    read data / bus drive enable
//   bc, bac                                               raw buttons (async)
//   led_x[7:0], led_y[7:0]                                LED column data / one-hot row
//   irq                                                   button interrupt (IO_PANEL_IRQ_EN only)
module io_panel_port
  import io_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_DIV        = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_sel,
  input  logic       io_strb,
  input  logic       io_we,
  input  logic       io_oe,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_en,
  input  logic       bc,
  input  logic       bac,
  output logic [7:0] led_x,
  output logic [7:0] led_y
`ifdef IO_PANEL_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic        acc, acc_q, ign_q;
  logic        acc_start, acc_end, wr_en;
  logic        rd_btn_q, btn_clr;
  logic [7:0]  dbg_q;
  logic [2:0]  ptr_q;
  logic [7:0]  frame_q [8];
  logic        scan_en_q;
  logic        ctrl_irq_mask;
  logic        cw_stable, acw_stable, cw_stable_q, acw_stable_q;
  logic        cw_evt, acw_evt;
  logic [15:0] div_q;
  logic [2:0]  row_q;
  logic [7:0]  rd_dat;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cw (
    .clk    (clk),
    .reset  (reset),
    .btn    (bc),
    .stable (cw_stable)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_acw (
    .clk    (clk),
    .reset  (reset),
    .btn    (bac),
    .stable (acw_stable)
  );

  // ign_q comes out of reset high so an access already in progress when
  // reset releases is not mistaken for a new one; it clears once acc drops.
  always_comb begin
    acc       = io_sel & io_strb;
    acc_start = acc & ~acc_q & ~ign_q;
    acc_end   = ~acc & acc_q;
    wr_en     = acc_start & io_we;
    btn_clr   = acc_end & rd_btn_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q    <= 1'b0;
      ign_q    <= 1'b1;
      rd_btn_q <= 1'b0;
    end else begin
      acc_q <= acc;
      if (!acc) ign_q <= 1'b0;
      // Remember at strobe start whether this is a BTN read, so the clear
      // fires at strobe end even if addr/io_oe have already moved on.
      if (acc_start)    rd_btn_q <= io_oe & ~io_we & (addr == IO_ADDR_BTN);
      else if (acc_end) rd_btn_q <= 1'b0;
    end
  end

  // Register file writes
  always_ff @(posedge clk) begin
    if (!reset) begin
      dbg_q     <= '0;
      ptr_q     <= '0;
      scan_en_q <= 1'b0;
      for (int i = 0; i < 8; i++) frame_q[i] <= '0;
    end else if (wr_en) begin
      case (addr)
        IO_ADDR_DBG:    dbg_q <= din;
        IO_ADDR_ROWPTR: ptr_q <= din[2:0];
        IO_ADDR_ROWDATA: begin
          frame_q[ptr_q] <= din;
          ptr_q          <= ptr_q + 3'd1;
        end
        IO_ADDR_CTRL:   scan_en_q <= din[CTRL_SCAN_EN];
        default: ;
      endcase
    end
  end

  // Button events: a rising stable level sets the sticky bit; set beats clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cw_stable_q  <= 1'b0;
      acw_stable_q <= 1'b0;
      cw_evt       <= 1'b0;
      acw_evt      <= 1'b0;
    end else begin
      cw_stable_q  <= cw_stable;
      acw_stable_q <= acw_stable;
      cw_evt       <= (cw_evt  & ~btn_clr) | (cw_stable  & ~cw_stable_q);
      acw_evt      <= (acw_evt & ~btn_clr) | (acw_stable & ~acw_stable_q);
    end
  end

`ifdef IO_PANEL_IRQ_EN
  logic irq_mask_q;

  assign ctrl_irq_mask = irq_mask_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_mask_q <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_en && addr == IO_ADDR_CTRL) irq_mask_q <= din[CTRL_IRQ_MASK];
      irq <= irq_mask_q & (cw_evt | acw_evt);
    end
  end
`else
  assign ctrl_irq_mask = 1'b0;
`endif

  // Row scanner
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q <= '0;
      row_q <= '0;
      led_x <= '0;
      led_y <= '0;
    end else if (!scan_en_q) begin
      div_q <= '0;
      row_q <= '0;
      led_x <= '0;
      led_y <= '0;
    end else begin
      if (div_q == SCAN_LAST) begin
        div_q <= '0;
        row_q <= row_q + 3'd1;
      end else begin
        div_q <= div_q + 16'd1;
      end
      led_y <= 8'b1 << row_q;
      led_x <= frame_q[row_q];
    end
  end

  // Read path
  always_comb begin
    rd_dat = '0;
    case (addr)
      IO_ADDR_DBG:     rd_dat = dbg_q;
      IO_ADDR_BTN:     rd_dat = {4'b0, cw_stable, acw_stable, cw_evt, acw_evt};
      IO_ADDR_ROWPTR:  rd_dat = {5'b0, ptr_q};
      IO_ADDR_ROWDATA: rd_dat = frame_q[ptr_q];
      IO_ADDR_CTRL:    rd_dat = {6'b0, ctrl_irq_mask, scan_en_q};
      default:         rd_dat = '0;
    endcase
    // A simultaneous write+read is treated as a write only; the bus is
    // never driven during reset or during an access straddling its release.
    dout_en = acc & io_oe & ~io_we & addr_mapped(addr) & reset & ~ign_q;
    dout    = dout_en ? rd_dat : 8'h00;
  end

endmodule

// File: tb/tb_io_panel_port.sv
module tb_io_panel_port;
  import io_panel_pkg::*;

  localparam int DB = 8;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_sel, io_strb, io_we, io_oe;
  logic [7:0] addr, din, dout, led_x, led_y;
  logic       dout_en, bc, bac;
`ifdef IO_PANEL_IRQ_EN
  logic       irq;
`endif

  always #5 clk = ~clk;

  io_panel_port #(.DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD)) dut (
    .clk     (clk),
    .reset   (reset),
    .io_sel  (io_sel),
    .io_strb (io_strb),
    .io_we   (io_we),
    .io_oe   (io_oe),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .dout_en (dout_en),
    .bc      (bc),
    .bac     (bac),
    .led_x   (led_x),
    .led_y   (led_y)
`ifdef IO_PANEL_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  dbg_m, ctrl_m;
  logic [2:0]  ptr_m;
  logic [7:0]  frame_m [8];
  logic [63:0] hist_cw, hist_acw;   // raw button samples, newest in bit 0
  logic        stab_cw, stab_acw, rose_cw, rose_acw, evt_cw, evt_acw;
  logic        clr_req = 1'b0;
  int unsigned cyc = 0;
  int unsigned last_wr_cyc = 0;

  // A level is accepted once the synchronized input (raw delayed two clocks)
  // has disagreed with the accepted level for DB consecutive clocks.
  function automatic logic window_differs(input logic [63:0] h, input logic s);
    for (int i = 1; i <= DB; i++) if (h[i] == s) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      hist_cw <= '0; hist_acw <= '0;
      stab_cw <= 1'b0; stab_acw <= 1'b0;
      rose_cw <= 1'b0; rose_acw <= 1'b0;
      evt_cw  <= 1'b0; evt_acw  <= 1'b0;
    end else begin
      evt_cw  <= (evt_cw  & ~clr_req) | rose_cw;
      evt_acw <= (evt_acw & ~clr_req) | rose_acw;
      rose_cw  <= 1'b0;
      rose_acw <= 1'b0;
      if (window_differs(hist_cw, stab_cw)) begin
        stab_cw <= ~stab_cw; rose_cw <= ~stab_cw;
      end
      if (window_differs(hist_acw, stab_acw)) begin
        stab_acw <= ~stab_acw; rose_acw <= ~stab_acw;
      end
      hist_cw  <= {hist_cw[62:0], bc};
      hist_acw <= {hist_acw[62:0], bac};
    end
  end

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    case (a)
      IO_ADDR_DBG:     return dbg_m;
      IO_ADDR_BTN:     return {4'b0, stab_cw, stab_acw, evt_cw, evt_acw};
      IO_ADDR_ROWPTR:  return {5'b0, ptr_m};
      IO_ADDR_ROWDATA: return frame_m[ptr_m];
`ifdef IO_PANEL_IRQ_EN
      IO_ADDR_CTRL:    return ctrl_m & 8'h03;
`else
      IO_ADDR_CTRL:    return ctrl_m & 8'h01;
`endif
      default:         return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    dbg_m = 8'h00; ctrl_m = 8'h00; ptr_m = 3'd0;
    for (int i = 0; i < 8; i++) frame_m[i] = 8'h00;
  endtask

  // ---------------- bus tasks ----------------
  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic both);
    @(negedge clk);
    io_sel = 1'b1; io_strb = 1'b1; io_we = 1'b1; io_oe = both; addr = a; din = d;
    if (both) begin
      #1 chk("wr_and_rd.dout_en", 32'(dout_en), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    last_wr_cyc = cyc;
    io_sel = 1'b0; io_strb = 1'b0; io_we = 1'b0; io_oe = 1'b0;
    @(posedge clk);
    case (a)
      IO_ADDR_DBG:     dbg_m = d;
      IO_ADDR_ROWPTR:  ptr_m = d[2:0];
      IO_ADDR_ROWDATA: begin frame_m[ptr_m] = d; ptr_m = ptr_m + 3'd1; end
      IO_ADDR_CTRL:    ctrl_m = d & 8'h03;
      default: ;
    endcase
  endtask

  task automatic rd(input logic [7:0] a, input string tag, output logic [7:0] d);
    logic [7:0] exp;
    logic       exp_en;
    @(negedge clk);
    io_sel = 1'b1; io_strb = 1'b1; io_oe = 1'b1; io_we = 1'b0; addr = a;
    #1;
    exp_en = (a <= 8'h04);
    exp    = exp_en ? exp_rd(a) : 8'h00;
    d      = dout;
    chk({tag, ".dout_en"}, 32'(dout_en), 32'(exp_en));
    chk({tag, ".dout"}, 32'(dout), 32'(exp));
    @(posedge clk);
    @(negedge clk);
    io_sel = 1'b0; io_strb = 1'b0; io_oe = 1'b0;
    clr_req = (a == IO_ADDR_BTN);
    #1 chk({tag, ".dout_en_after"}, 32'(dout_en), 32'd0);
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int t;
    reset = 1'b0; io_sel = 1'b0; io_strb = 1'b0; io_we = 1'b0; io_oe = 1'b0;
    addr = 8'h00; din = 8'h00; bc = 1'b0; bac = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.led_x", 32'(led_x), 32'd0);
    chk("rst.led_y", 32'(led_y), 32'd0);
    chk("rst.dout_en", 32'(dout_en), 32'd0);
    chk("rst.dout", 32'(dout), 32'd0);
`ifdef IO_PANEL_IRQ_EN
    chk("rst.irq", 32'(irq), 32'd0);
`endif
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Scratch register, unmapped read, write+read collision
    wr(IO_ADDR_DBG, 8'h5A, 1'b0);
    rd(IO_ADDR_DBG, "dbg", d);
    chk("dbg.const", 32'(d), 32'h5A);
    rd(8'h07, "unmapped", d);
    rd(IO_ADDR_BTN, "btn_idle", d);
    wr(IO_ADDR_DBG, 8'h33, 1'b1);
    rd(IO_ADDR_DBG, "dbg_both", d);

    // Frame buffer pointer auto-increment and wrap
    wr(IO_ADDR_ROWPTR, 8'h07, 1'b0);
    wr(IO_ADDR_ROWDATA, 8'hAA, 1'b0);
    wr(IO_ADDR_ROWDATA, 8'h55, 1'b0);
    rd(IO_ADDR_ROWPTR, "ptr_wrap", d);
    chk("ptr_wrap.const", 32'(d), 32'd1);
    wr(IO_ADDR_ROWPTR, 8'h07, 1'b0);
    rd(IO_ADDR_ROWDATA, "frame7", d);
    chk("frame7.const", 32'(d), 32'hAA);
    wr(IO_ADDR_ROWPTR, 8'h00, 1'b0);
    rd(IO_ADDR_ROWDATA, "frame0", d);
    chk("frame0.const", 32'(d), 32'h55);
    for (int i = 0; i < 8; i++) wr(IO_ADDR_ROWDATA, 8'($urandom_range(0, 255)), 1'b0);
    rd(IO_ADDR_ROWPTR, "ptr_full_wrap", d);
    rd(IO_ADDR_CTRL, "ctrl_idle", d);

    // Scanning: row r is shown for SD cycles starting one cycle after enable
    wr(IO_ADDR_CTRL, 8'h01, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      t = int'(cyc - last_wr_cyc) - 1;
      chk("scan.led_y", 32'(led_y), 32'(8'd1 << ((t / SD) % 8)));
      chk("scan.led_x", 32'(led_x), 32'(frame_m[(t / SD) % 8]));
    end
    rd(IO_ADDR_CTRL, "ctrl_on", d);
    wr(IO_ADDR_CTRL, 8'h00, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("scan_off.led_x", 32'(led_x), 32'd0);
      chk("scan_off.led_y", 32'(led_y), 32'd0);
    end

    // Short bc pulses are rejected
    for (int w = 1; w < DB; w++) begin
      @(negedge clk); bc = 1'b1;
      repeat (w) @(negedge clk);
      bc = 1'b0;
      repeat (10) @(negedge clk);
    end
    rd(IO_ADDR_BTN, "btn_short", d);
    chk("btn_short.const", 32'(d), 32'h00);

    // Long bc press: event + level, then read-to-clear leaves only the level
    @(negedge clk); bc = 1'b1;
    repeat (20) @(negedge clk);
    rd(IO_ADDR_BTN, "btn_long1", d);
    chk("btn_long1.const", 32'(d), 32'h0A);
    rd(IO_ADDR_BTN, "btn_long2", d);
    chk("btn_long2.const", 32'(d), 32'h08);
    bc = 1'b0;
    repeat (15) @(negedge clk);

    // bac event rises on the very edge that ends a BTN read: set wins
    bac = 1'b1;
    repeat (DB + 1) @(posedge clk);
    rd(IO_ADDR_BTN, "race1", d);
    chk("race1.bit0", 32'(d[0]), 32'd0);
    rd(IO_ADDR_BTN, "race2", d);
    chk("race2.bit0", 32'(d[0]), 32'd1);
    bac = 1'b0;
    repeat (15) @(negedge clk);
    rd(IO_ADDR_BTN, "race3", d);

    // Randomized buttons and scratch traffic against the model
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bc  = 1'($urandom_range(0, 1));
      bac = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 25)) @(negedge clk);
      rd(IO_ADDR_BTN, "btn_rand", d);
      if ($urandom_range(0, 3) == 0) begin
        wr(IO_ADDR_DBG, 8'($urandom_range(0, 255)), 1'b0);
        rd(IO_ADDR_DBG, "dbg_rand", d);
      end
    end

`ifdef IO_PANEL_IRQ_EN
    @(negedge clk); bc = 1'b0; bac = 1'b0;
    repeat (15) @(negedge clk);
    rd(IO_ADDR_BTN, "irq.pre", d);
    wr(IO_ADDR_CTRL, 8'h03, 1'b0);
    rd(IO_ADDR_CTRL, "irq.ctrl", d);
    @(negedge clk);
    chk("irq.idle", 32'(irq), 32'd0);
    bc = 1'b1;
    repeat (DB + 6) @(posedge clk);
    @(negedge clk);
    chk("irq.set", 32'(irq), 32'd1);
    rd(IO_ADDR_BTN, "irq.btn", d);
    @(posedge clk);
    @(negedge clk);
    chk("irq.clear", 32'(irq), 32'd0);
`endif

    // Reset mid-scan with a read in flight, then straddling accesses
    wr(IO_ADDR_CTRL, 8'h01, 1'b0);
    repeat (10) @(negedge clk);
    chk("prerst.led_y_active", 32'(led_y != 8'h00), 32'd1);
    reset = 1'b0;
    io_sel = 1'b1; io_strb = 1'b1; io_oe = 1'b1; addr = IO_ADDR_DBG;
    @(posedge clk);
    @(negedge clk);
    chk("midrst.led_x", 32'(led_x), 32'd0);
    chk("midrst.led_y", 32'(led_y), 32'd0);
    chk("midrst.dout_en", 32'(dout_en), 32'd0);
    chk("midrst.dout", 32'(dout), 32'd0);
`ifdef IO_PANEL_IRQ_EN
    chk("midrst.irq", 32'(irq), 32'd0);
`endif
    model_reset();
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("straddle_rd.dout_en", 32'(dout_en), 32'd0);
    end
    io_sel = 1'b0; io_strb = 1'b0; io_oe = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    io_sel = 1'b1; io_strb = 1'b1; io_we = 1'b1; addr = IO_ADDR_DBG; din = 8'h77;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    io_sel = 1'b0; io_strb = 1'b0; io_we = 1'b0;
    rd(IO_ADDR_DBG, "postrst.dbg", d);
    rd(IO_ADDR_ROWDATA, "postrst.frame", d);
    rd(IO_ADDR_CTRL, "postrst.ctrl", d);
    rd(IO_ADDR_BTN, "postrst.btn", d);
    @(negedge clk);
    chk("postrst.led_y", 32'(led_y), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
